reg_file_param: RTL and testbench

Parametrised successor to the 16×32 ARM-style register file: three asynchronous read ports (Rn, Rm, Rs), one synchronous write port (Rd), data width and register count set by parameters. It adds a synchronous reset-driven clear sequencer, which writes a known value into every register one per cycle and reports `busy` while doing so. It also adds optional same-cycle write-to-read bypass. It sits between decode (addresses) and the execute/writeback stages of the core datapath.

---
 rtl/reg_file_param.sv | 101 ++++++++++
 tb/tb_reg_file_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with three asynchronous read
// ports (rn, rm, rs) and one synchronous write port (rd). A clear sequencer
// writes INIT_VAL into every register, one per cycle, after reset; busy is
// high while it runs, writes are ignored and read ports return zero.
// Optional feature macro: REG_FILE_BYPASS_EN -- when defined, a read port whose
// address matches an accepted write returns rd_data in the same cycle.
module reg_file_param #(
  parameter int            DW       = 32,
  parameter int            AW       = 4,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rn_addr,
  input  logic [AW-1:0] rm_addr,
  input  logic [AW-1:0] rs_addr,
  output logic [DW-1:0] rn_data,
  output logic [DW-1:0] rm_data,
  output logic [DW-1:0] rs_data,
  input  logic          w_en,
  input  logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          busy
);

  localparam int            DEPTH   = 2 ** AW;
  localparam logic [AW-1:0] CNT_MAX = AW'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          arr_we;
  logic [AW-1:0] arr_waddr;
  logic [DW-1:0] arr_wdata;

  // Next-state and array write selection: the clear sequencer owns the write
  // port while in CLEAR, the external rd port owns it in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arr_we    = 1'b0;
    arr_waddr = rd_addr;
    arr_wdata = rd_data;
    if (state_q == CLEAR) begin
      arr_we    = 1'b1;
      arr_waddr = cnt_q;
      arr_wdata = INIT_VAL;
      if (cnt_q == CNT_MAX) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      arr_we = w_en;
    end
  end

  // Control state: reset restarts the clear sequence from register 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage array: reset blocks any write in the same cycle, including w_en.
  always_ff @(posedge clk) begin
    if (!rst && arr_we) begin
      mem_q[arr_waddr] <= arr_wdata;
    end
  end

  assign busy = (state_q == CLEAR);

  // Combinational read ports: zero while clearing, optional write bypass.
  always_comb begin
    rn_data = '0;
    rm_data = '0;
    rs_data = '0;
    if (state_q == RUN) begin
      rn_data = mem_q[rn_addr];
      rm_data = mem_q[rm_addr];
      rs_data = mem_q[rs_addr];
`ifdef REG_FILE_BYPASS_EN
      if (w_en && (rn_addr == rd_addr)) rn_data = rd_data;
      if (w_en && (rm_addr == rd_addr)) rm_data = rd_data;
      if (w_en && (rs_addr == rd_addr)) rs_data = rd_data;
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed, table-driven bench for reg_file_param.
// Three instances: default (INIT_VAL=0), INIT_VAL=0xDEADBEEF sharing the same
// inputs, and a narrow DW=8/AW=3 instance with its own inputs.
module tb_reg_file_param;

  logic        clk;
  logic        rst;
  logic [3:0]  rn_addr, rm_addr, rs_addr, rd_addr;
  logic [31:0] rd_data;
  logic        w_en;
  logic [31:0] rn0, rm0, rs0, rn1, rm1, rs1;
  logic        busy0, busy1;

  logic [2:0]  rn2_addr, rm2_addr, rs2_addr, rd2_addr;
  logic [7:0]  rd2_data, rn2, rm2, rs2;
  logic        w2_en, busy2;

  int n_chk;
  int n_fail;

  reg_file_param dut0 (
    .clk(clk), .rst(rst),
    .rn_addr(rn_addr), .rm_addr(rm_addr), .rs_addr(rs_addr),
    .rn_data(rn0), .rm_data(rm0), .rs_data(rs0),
    .w_en(w_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy0)
  );

  reg_file_param #(.INIT_VAL(32'hDEADBEEF)) dut1 (
    .clk(clk), .rst(rst),
    .rn_addr(rn_addr), .rm_addr(rm_addr), .rs_addr(rs_addr),
    .rn_data(rn1), .rm_data(rm1), .rs_data(rs1),
    .w_en(w_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy1)
  );

  reg_file_param #(.DW(8), .AW(3), .INIT_VAL(8'h00)) dut2 (
    .clk(clk), .rst(rst),
    .rn_addr(rn2_addr), .rm_addr(rm2_addr), .rs_addr(rs2_addr),
    .rn_data(rn2), .rm_data(rm2), .rs_data(rs2),
    .w_en(w2_en), .rd_addr(rd2_addr), .rd_data(rd2_data), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        w;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  an, am, as;
    logic [31:0] en, em, es;
  } vec_t;

  vec_t tbl [7];

  logic [31:0] bypass_exp;
  int b0, b1, b2, bm;

  initial begin
    // Reads are sampled before the edge, so a row's write is seen by later rows.
    tbl[0] = '{1'b1, 4'd5,  32'h12345678, 4'd0,  4'd1,  4'd2, 32'h0,         32'h0,         32'h0};
    tbl[1] = '{1'b1, 4'd15, 32'hA5A5A5A5, 4'd5,  4'd14, 4'd5, 32'h12345678,  32'h0,         32'h12345678};
    tbl[2] = '{1'b0, 4'd0,  32'h0,        4'd5,  4'd15, 4'd5, 32'h12345678,  32'hA5A5A5A5,  32'h12345678};
    tbl[3] = '{1'b0, 4'd0,  32'h0,        4'd0,  4'd1,  4'd2, 32'h0,         32'h0,         32'h0};
    tbl[4] = '{1'b0, 4'd0,  32'h0,        4'd3,  4'd4,  4'd6, 32'h0,         32'h0,         32'h0};
    tbl[5] = '{1'b1, 4'd7,  32'h00000001, 4'd14, 4'd13, 4'd8, 32'h0,         32'h0,         32'h0};
    tbl[6] = '{1'b0, 4'd0,  32'h0,        4'd7,  4'd9,  4'd15, 32'h1,        32'h0,         32'hA5A5A5A5};

    n_chk = 0; n_fail = 0;
    rst = 1'b1; w_en = 1'b0; rd_addr = '0; rd_data = '0;
    rn_addr = 4'd15; rm_addr = 4'd5; rs_addr = 4'd3;
    w2_en = 1'b0; rd2_addr = '0; rd2_data = '0;
    rn2_addr = '0; rm2_addr = '0; rs2_addr = '0;

    // Reset held three cycles
    @(posedge clk); #1;
    chk("reset_busy0", {31'd0, busy0}, 32'd1);
    chk("reset_busy2", {31'd0, busy2}, 32'd1);
    chk("reset_rn0_zero", rn0, 32'd0);
    chk("reset_rm1_zero", rm1, 32'd0);
    repeat (2) @(posedge clk);

    // Release with a write request held through the whole clear
    @(negedge clk);
    rst = 1'b0; w_en = 1'b1; rd_addr = 4'd3; rd_data = 32'hFFFFFFFF;
    b0 = 0; b1 = 0; b2 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (busy0) chk("clear_read_zero", rn0 | rm0 | rs0, 32'd0);
      if (!busy0 && b0 == 0) b0 = i;
      if (!busy1 && b1 == 0) b1 = i;
      if (!busy2 && b2 == 0) b2 = i;
      if (b0 != 0 && b1 != 0 && b2 != 0) break;
    end
    chk("clear_len_dut0", b0, 16);
    chk("clear_len_dut1", b1, 16);
    chk("clear_len_dw8",  b2, 8);
    @(negedge clk);
    w_en = 1'b0;

    // Every register holds INIT_VAL; r3 must not have taken the held write
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      rn_addr = 4'(a); rm_addr = 4'(a); rs_addr = 4'(a);
      rn2_addr = 3'(a);
      #1;
      chk($sformatf("init_rn0_r%0d", a), rn0, 32'h0);
      chk($sformatf("init_rs1_r%0d", a), rs1, 32'hDEADBEEF);
      if (a < 8) chk($sformatf("init_dw8_r%0d", a), {24'd0, rn2}, 32'h0);
    end

    // Table-driven write/read vectors on the default instance
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      w_en = tbl[k].w; rd_addr = tbl[k].wa; rd_data = tbl[k].wd;
      rn_addr = tbl[k].an; rm_addr = tbl[k].am; rs_addr = tbl[k].as;
      #1;
      chk($sformatf("vec%0d_rn", k), rn0, tbl[k].en);
      chk($sformatf("vec%0d_rm", k), rm0, tbl[k].em);
      chk($sformatf("vec%0d_rs", k), rs0, tbl[k].es);
    end

    // Same-cycle write and read of r7 (holds 0x1)
`ifdef REG_FILE_BYPASS_EN
    bypass_exp = 32'h2;
`else
    bypass_exp = 32'h1;
`endif
    @(negedge clk);
    w_en = 1'b1; rd_addr = 4'd7; rd_data = 32'h2;
    rn_addr = 4'd7; rm_addr = 4'd7; rs_addr = 4'd7;
    #1;
    chk("bypass_rn", rn0, bypass_exp);
    chk("bypass_rm", rm0, bypass_exp);
    chk("bypass_rs", rs0, bypass_exp);
    @(negedge clk);
    w_en = 1'b0;
    #1;
    chk("after_write_rn", rn0, 32'h2);
    chk("after_write_rs", rs0, 32'h2);

    // Narrow instance: 0xFF to r7, others stay INIT_VAL
    @(negedge clk);
    w2_en = 1'b1; rd2_addr = 3'd7; rd2_data = 8'hFF;
    @(negedge clk);
    w2_en = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rn2_addr = 3'(a); rm2_addr = 3'(7 - a); rs2_addr = 3'd7;
      #1;
      chk($sformatf("dw8_rn_r%0d", a), {24'd0, rn2}, (a == 7) ? 32'hFF : 32'h0);
      chk($sformatf("dw8_rm_r%0d", 7 - a), {24'd0, rm2}, (a == 0) ? 32'hFF : 32'h0);
      chk("dw8_rs_r7", {24'd0, rs2}, 32'hFF);
    end

    // Reset in RUN with a simultaneous write, then reset again at cnt=9
    @(negedge clk);
    rst = 1'b1; w_en = 1'b1; rd_addr = 4'd5; rd_data = 32'h00000777;
    rn_addr = 4'd15; rm_addr = 4'd5; rs_addr = 4'd14;
    @(negedge clk);
    chk("run_reset_busy", {31'd0, busy0}, 32'd1);
    chk("run_reset_rn_zero", rn0, 32'd0);
    rst = 1'b0; w_en = 1'b0;
    repeat (9) @(negedge clk);
    chk("midclear_busy", {31'd0, busy0}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bm = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (busy0) begin
        chk("midclear_read_zero", rn0 | rm0 | rs0, 32'd0);
      end else begin
        bm = i;
        break;
      end
    end
    chk("midclear_len", bm, 16);
    @(negedge clk);
    rn_addr = 4'd15; rm_addr = 4'd5; rs_addr = 4'd7;
    #1;
    chk("recleared_r15", rn0, 32'h0);
    chk("recleared_r5",  rm0, 32'h0);
    chk("recleared_r7",  rs0, 32'h0);
    chk("recleared_dut1_r5", rm1, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
